// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: program-RAM read port plus the instruction handshake to decode.
// The master side is the fetch unit; the slave side is the RAM/decode environment.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output mem_rd_en, mem_addr, instr_valid, instr, instr_pc,
        input  mem_rdata, instr_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, instr_valid, instr, instr_pc,
        output mem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited reads to a
// synchronous program RAM, queues returned words with their PCs, and flushes on redirect.
module fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_out,
    fetch_unit_if.master      bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    entry_t            fifo_d [DEPTH];
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W:0]    inflight_s;
    logic              issue_s, push_s, pop_s, valid_s;

    // Issue/push/pop decisions and next-state for PC, credit and FIFO.
    always_comb begin
        // Credits count both queued entries and the read still in flight, so a push never overflows.
        inflight_s = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q};
        valid_s    = (count_q != {CNT_W{1'b0}}) && !redirect_valid;
        issue_s    = reset && fetch_en && !redirect_valid && (inflight_s < DEPTH_V);
        push_s     = pending_q && !redirect_valid;
        pop_s      = valid_s && bus.instr_ready;
        pending_d  = issue_s;
        fifo_d     = fifo_q;

        if (push_s) begin
            fifo_d[wr_ptr_q] = {bus.mem_rdata, issued_pc_q};
        end else begin
            fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
        end

        if (issue_s) begin
            issued_pc_d = fetch_pc_q;
        end else begin
            issued_pc_d = issued_pc_q;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            count_d    = {CNT_W{1'b0}};
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
        end else begin
            if (issue_s) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1'b1);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
        end
    end

    // State registers; reset also abandons any outstanding read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q  <= {ADDR_W{1'b0}};
            issued_pc_q <= {ADDR_W{1'b0}};
            pending_q   <= 1'b0;
            count_q     <= {CNT_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= {($bits(entry_t)){1'b0}};
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_q      <= fifo_d;
        end
    end

    assign bus.mem_rd_en   = issue_s;
    assign bus.mem_addr    = fetch_pc_q;
    assign bus.instr_valid = valid_s;
    assign bus.instr       = fifo_q[rd_ptr_q].word;
    assign bus.instr_pc    = fifo_q[rd_ptr_q].pc;
    assign pc_out          = fetch_pc_q;

endmodule
